// File: rtl/dcd_sched_pkg.sv
// Shared definitions for the decision scheduler: FSM encoding, variable value
// codes and the constant value written for every decision.
package dcd_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SCAN  = 2'b01,
        ST_ISSUE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam logic [1:0] VAL_FREE  = 2'b00;
    localparam logic [1:0] VAL_FALSE = 2'b01;
    localparam logic [1:0] VAL_TRUE  = 2'b10;

    // Decisions always take the false phase and are never marked implied.
    localparam logic [2:0] DCD_VALUE = {VAL_FALSE, 1'b0};

    function automatic logic is_free(input logic [1:0] val);
        return val == VAL_FREE;
    endfunction

endpackage

// File: rtl/dcd_sched_var_check.sv
// Free-entry test and one-hot index generation for the entry currently
// selected by the scan pointer.
module dcd_var_check
    import dcd_sched_pkg::*;
#(
    parameter int NUM_VARS = 8,
    parameter int WIDTH    = 3,
    parameter int PTR_W    = 3
) (
    input  logic [WIDTH-1:0]    entry_i,
    input  logic [PTR_W-1:0]    ptr_i,
    output logic                free_o,
    output logic [NUM_VARS-1:0] index_o
);

    // The implied flag has no bearing on whether a variable is free.
    logic unused_implied;
    assign unused_implied = entry_i[0];

    assign free_o  = is_free(entry_i[2:1]);
    assign index_o = NUM_VARS'(1) << ptr_i;

endmodule

// File: rtl/dcd_sched.sv
// Decision scheduler: on request, scans the variable list one entry per cycle
// and presents the first free variable as a decision with a valid/ack handshake.
module dcd_sched
    import dcd_sched_pkg::*;
#(
    parameter int NUM_VARS = 8,
    parameter int WIDTH    = 3,
    parameter int LVL_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [NUM_VARS*WIDTH-1:0] value_i,
    input  logic                      dcd_ack_i,
    input  logic                      bkt_valid_i,
    input  logic [LVL_W-1:0]          bkt_level_i,
    output logic                      dcd_valid_o,
    output logic [NUM_VARS-1:0]       dcd_index_o,
    output logic [WIDTH-1:0]          dcd_value_o,
    output logic [LVL_W-1:0]          level_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      all_assigned_o
);

    localparam int               PTR_W    = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_VARS - 1);
    localparam logic [LVL_W-1:0] LVL_MAX  = '1;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [NUM_VARS-1:0]   index_q, index_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  all_assigned_q, all_assigned_d;

    logic [WIDTH-1:0]      cur_entry;
    logic                  cur_free;
    logic [NUM_VARS-1:0]   cur_index;

    assign cur_entry = value_i[ptr_q*WIDTH +: WIDTH];

    dcd_var_check #(
        .NUM_VARS (NUM_VARS),
        .WIDTH    (WIDTH),
        .PTR_W    (PTR_W)
    ) u_var_check (
        .entry_i  (cur_entry),
        .ptr_i    (ptr_q),
        .free_o   (cur_free),
        .index_o  (cur_index)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d        = state_q;
        ptr_d          = ptr_q;
        index_d        = index_q;
        level_d        = level_q;
        all_assigned_d = all_assigned_q;

        if (bkt_valid_i) begin
            // Backtrack wins over start and ack, and never produces done.
            level_d = bkt_level_i;
            index_d = '0;
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        ptr_d          = '0;
                        all_assigned_d = 1'b0;
                        state_d        = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (cur_free) begin
                        index_d = cur_index;
                        state_d = ST_ISSUE;
                    end else if (ptr_q == PTR_LAST) begin
                        all_assigned_d = 1'b1;
                        state_d        = ST_DONE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (dcd_ack_i) begin
                        level_d = (level_q == LVL_MAX) ? level_q : level_q + 1'b1;
                        index_d = '0;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            ptr_q          <= '0;
            index_q        <= '0;
            level_q        <= '0;
            all_assigned_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            index_q        <= index_d;
            level_q        <= level_d;
            all_assigned_q <= all_assigned_d;
        end
    end

    assign dcd_valid_o    = (state_q == ST_ISSUE);
    assign dcd_index_o    = index_q;
    assign dcd_value_o    = WIDTH'(DCD_VALUE);
    assign level_o        = level_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = (state_q == ST_DONE);
    assign all_assigned_o = all_assigned_q;

endmodule

// File: tb/tb_dcd_sched.sv
// Self-checking bench for dcd_sched: a scoreboard of expected decisions is filled
// when a request is issued and drained when the DUT presents a result.
module tb_dcd_sched;

    localparam int NV = 8;
    localparam int W  = 3;
    localparam int LW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic [NV*W-1:0]   value_i;
    logic              dcd_ack_i;
    logic              bkt_valid_i;
    logic [LW-1:0]     bkt_level_i;
    logic              dcd_valid_o;
    logic [NV-1:0]     dcd_index_o;
    logic [W-1:0]      dcd_value_o;
    logic [LW-1:0]     level_o;
    logic              busy_o;
    logic              done_o;
    logic              all_assigned_o;

    typedef struct {
        bit found;
        int idx;
    } exp_t;

    exp_t           sb[$];
    int             n_checks = 0;
    int             n_fail   = 0;
    logic [LW-1:0]  model_level;

    always #5 clk = ~clk;

    dcd_sched #(.NUM_VARS(NV), .WIDTH(W), .LVL_W(LW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .value_i        (value_i),
        .dcd_ack_i      (dcd_ack_i),
        .bkt_valid_i    (bkt_valid_i),
        .bkt_level_i    (bkt_level_i),
        .dcd_valid_o    (dcd_valid_o),
        .dcd_index_o    (dcd_index_o),
        .dcd_value_o    (dcd_value_o),
        .level_o        (level_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .all_assigned_o (all_assigned_o)
    );

    function automatic exp_t model(input logic [NV*W-1:0] v);
        exp_t e;
        e.found = 0;
        e.idx   = -1;
        for (int k = NV - 1; k >= 0; k--) begin
            if (v[k*W+2 -: 2] == 2'b00) begin
                e.found = 1;
                e.idx   = k;
            end
        end
        return e;
    endfunction

    function automatic logic [NV*W-1:0] rand_list(input int free_pct);
        logic [NV*W-1:0] v;
        logic [1:0]      code;
        for (int k = 0; k < NV; k++) begin
            if (int'($urandom_range(99)) < free_pct) code = 2'b00;
            else code = 2'($urandom_range(1, 2));
            v[k*W +: W] = {code, 1'($urandom_range(0, 1))};
        end
        return v;
    endfunction

    function automatic logic [NV*W-1:0] all_assigned_list();
        logic [NV*W-1:0] v;
        for (int k = 0; k < NV; k++) begin
            case (k % 4)
                0:       v[k*W +: W] = 3'b010;
                1:       v[k*W +: W] = 3'b101;
                2:       v[k*W +: W] = 3'b100;
                default: v[k*W +: W] = 3'b011;
            endcase
        end
        return v;
    endfunction

    // Issue one request and follow it through to its done pulse.
    task automatic run_request(input logic [NV*W-1:0] vals, input int ack_delay);
        exp_t          got;
        int            cyc;
        logic [NV-1:0] oh;
        logic [LW-1:0] exp_lvl;
        @(negedge clk);
        value_i = vals;
        start_i = 1'b1;
        sb.push_back(model(vals));
        @(negedge clk);
        start_i = 1'b0;
        cyc = 1;
        while (!dcd_valid_o && !done_o && cyc < 4 * NV) begin
            @(negedge clk);
            cyc++;
        end
        got = sb.pop_front();
        n_checks++;
        if (!dcd_valid_o && !done_o) begin
            n_fail++;
            $display("FAIL req_timeout: no valid/done after %0d cycles, required within %0d", cyc, NV + 1);
            return;
        end
        if (got.found) begin
            oh = NV'(1) << got.idx;
            n_checks++;
            if (cyc != got.idx + 2 || dcd_valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL req_latency: valid=%b after %0d cycles, required valid=1 after %0d", dcd_valid_o, cyc, got.idx + 2);
            end
            n_checks++;
            if (dcd_index_o !== oh) begin
                n_fail++;
                $display("FAIL req_index: got %h required %h", dcd_index_o, oh);
            end
            n_checks++;
            if (dcd_value_o !== 3'b010 || all_assigned_o !== 1'b0) begin
                n_fail++;
                $display("FAIL req_value: value=%b all_assigned=%b, required 010 and 0", dcd_value_o, all_assigned_o);
            end
            for (int i = 0; i < ack_delay; i++) begin
                start_i = (i == 0);
                @(negedge clk);
                start_i = 1'b0;
                n_checks++;
                if ({dcd_valid_o, done_o, dcd_index_o, dcd_value_o} !== {1'b1, 1'b0, oh, 3'b010}) begin
                    n_fail++;
                    $display("FAIL hold_stable: valid=%b done=%b index=%h value=%b, required 1 0 %h 010",
                             dcd_valid_o, done_o, dcd_index_o, dcd_value_o, oh);
                end
            end
            dcd_ack_i = 1'b1;
            @(negedge clk);
            dcd_ack_i = 1'b0;
            exp_lvl = (model_level == 4'hF) ? model_level : model_level + 4'd1;
            model_level = exp_lvl;
            n_checks++;
            if ({dcd_valid_o, done_o, dcd_index_o} !== {1'b0, 1'b1, {NV{1'b0}}}) begin
                n_fail++;
                $display("FAIL ack_done: valid=%b done=%b index=%h, required 0 1 00", dcd_valid_o, done_o, dcd_index_o);
            end
            n_checks++;
            if (level_o !== exp_lvl) begin
                n_fail++;
                $display("FAIL ack_level: got %h required %h", level_o, exp_lvl);
            end
        end else begin
            n_checks++;
            if (cyc != NV + 1 || done_o !== 1'b1 || dcd_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL full_latency: done=%b valid=%b after %0d cycles, required 1 0 after %0d", done_o, dcd_valid_o, cyc, NV + 1);
            end
            n_checks++;
            if (all_assigned_o !== 1'b1 || level_o !== model_level) begin
                n_fail++;
                $display("FAIL full_flags: all_assigned=%b level=%h, required 1 %h", all_assigned_o, level_o, model_level);
            end
        end
        @(negedge clk);
        n_checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || all_assigned_o !== !got.found) begin
            n_fail++;
            $display("FAIL after_done: done=%b busy=%b all_assigned=%b, required 0 0 %b", done_o, busy_o, all_assigned_o, !got.found);
        end
    endtask

    task automatic load_level(input logic [LW-1:0] lvl);
        @(negedge clk);
        bkt_valid_i = 1'b1;
        bkt_level_i = lvl;
        @(negedge clk);
        bkt_valid_i = 1'b0;
        model_level = lvl;
        n_checks++;
        if (level_o !== lvl || done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL load_level: level=%h done=%b busy=%b, required %h 0 0", level_o, done_o, busy_o, lvl);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({dcd_valid_o, dcd_index_o, level_o, busy_o, done_o, all_assigned_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b index=%h level=%h busy=%b done=%b all=%b, required all zero",
                     dcd_valid_o, dcd_index_o, level_o, busy_o, done_o, all_assigned_o);
        end
        n_checks++;
        if (dcd_value_o !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_value: got %b required 010", dcd_value_o);
        end
        rst_n = 1'b1;
        model_level = '0;
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b done=%b, required 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_all_free();
        run_request('0, 0);
    endtask

    task automatic test_delayed_ack();
        logic [NV*W-1:0] v;
        v = '0;
        v[0*W +: W] = 3'b010;
        v[1*W +: W] = 3'b100;
        v[2*W +: W] = 3'b011;
        v[3*W +: W] = 3'b101;
        v[4*W +: W] = 3'b010;
        v[5*W +: W] = 3'b001;
        run_request(v, 3);
    endtask

    task automatic test_all_assigned();
        run_request(all_assigned_list(), 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            run_request(rand_list(12 + r * 5), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_ack_ignored();
        @(negedge clk);
        dcd_ack_i = 1'b1;
        repeat (2) @(negedge clk);
        dcd_ack_i = 1'b0;
        n_checks++;
        if (level_o !== model_level || dcd_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_idle: level=%h valid=%b busy=%b, required %h 0 0", level_o, dcd_valid_o, busy_o, model_level);
        end
    endtask

    task automatic test_backtrack();
        load_level(4'd5);
        @(negedge clk);
        value_i = '0;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dcd_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bkt_setup: valid=%b required 1", dcd_valid_o);
        end
        bkt_valid_i = 1'b1;
        bkt_level_i = 4'd2;
        dcd_ack_i   = 1'b1;
        @(negedge clk);
        bkt_valid_i = 1'b0;
        dcd_ack_i   = 1'b0;
        model_level = 4'd2;
        n_checks++;
        if ({level_o, dcd_valid_o, dcd_index_o, busy_o, done_o} !== {4'd2, 1'b0, {NV{1'b0}}, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL bkt_issue: level=%h valid=%b index=%h busy=%b done=%b, required 2 0 00 0 0",
                     level_o, dcd_valid_o, dcd_index_o, busy_o, done_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL bkt_no_done: done=%b busy=%b, required 0 0", done_o, busy_o);
            end
        end
    endtask

    task automatic test_bkt_during_scan();
        @(negedge clk);
        value_i = all_assigned_list();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_busy: busy=%b required 1", busy_o);
        end
        bkt_valid_i = 1'b1;
        bkt_level_i = 4'hC;
        start_i     = 1'b1;
        @(negedge clk);
        bkt_valid_i = 1'b0;
        start_i     = 1'b0;
        model_level = 4'hC;
        n_checks++;
        if (level_o !== 4'hC || busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bkt_scan: level=%h busy=%b done=%b, required c 0 0", level_o, busy_o, done_o);
        end
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bkt_start_override: busy=%b done=%b, required 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_saturate();
        load_level(4'hF);
        run_request(rand_list(40) & {NV{3'b001}}, 1);
    endtask

    task automatic test_async_reset();
        load_level(4'd3);
        @(negedge clk);
        value_i = all_assigned_list();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_setup: busy=%b required 1", busy_o);
        end
        #2 rst_n = 1'b0;
        #1;
        model_level = '0;
        n_checks++;
        if ({dcd_valid_o, dcd_index_o, level_o, busy_o, done_o, all_assigned_o} !== '0 || dcd_value_o !== 3'b010) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b index=%h level=%h busy=%b done=%b all=%b value=%b, required zeros and 010",
                     dcd_valid_o, dcd_index_o, level_o, busy_o, done_o, all_assigned_o, dcd_value_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_hold: done=%b busy=%b, required 0 0", done_o, busy_o);
            end
        end
        rst_n = 1'b1;
        run_request(rand_list(30), 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        start_i     = 1'b0;
        value_i     = '0;
        dcd_ack_i   = 1'b0;
        bkt_valid_i = 1'b0;
        bkt_level_i = '0;
        model_level = '0;
        test_reset();
        test_all_free();
        test_delayed_ack();
        test_all_assigned();
        test_random();
        test_ack_ignored();
        test_backtrack();
        test_bkt_during_scan();
        test_saturate();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

endmodule
